// File: rtl/adc_sample_buffer_pkg.sv
// temp_pkg: shared widths and defaults for the temperature-readout slice
package temp_pkg;
  localparam int ADC_DATA_W = 12;
  localparam int AVG_LOG2_DEF = 3;
  localparam int DEPTH_LOG2_DEF = 6;
  localparam int LED_W = 8;
endpackage

// File: rtl/adc_sample_buffer_if.sv
// adc_sample_buffer_if: ADC sample stream, FIFO read port, status and LED bus
interface adc_sample_buffer_if
  import temp_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
  logic adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic rd_en;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic [DEPTH_LOG2:0] count;
  logic empty;
  logic full;
  logic overflow;
  logic ovf_clr;
  logic [LED_W-1:0] led_dout;
  modport master (
    output adc_valid, adc_data, rd_en, ovf_clr,
    input rd_data, rd_valid, count, empty, full, overflow, led_dout
  );
  modport slave (
    input adc_valid, adc_data, rd_en, ovf_clr,
    output rd_data, rd_valid, count, empty, full, overflow, led_dout
  );
endinterface

// File: rtl/adc_sample_buffer_sample_ram.sv
// sample_ram: simple dual-port RAM with one write port and a registered read port
module sample_ram #(
  parameter int W = 12,
  parameter int A = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [A-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [A-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [1<<A];
  // storage array, no reset so it maps onto block RAM
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register, holds the last popped word between reads
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer: box-car averages ADC samples into a circular FIFO and drives the LED bus
module adc_sample_buffer
  import temp_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic clk,
  input logic rst,
  adc_sample_buffer_if.slave bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [ACC_W-1:0] acc, sum;
  logic [AVG_LOG2-1:0] cnt;
  logic [DATA_W-1:0] avg;
  logic push_req, do_pop, do_push, drop;
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0] count_nx;
  // final sample of a group pushes in the same cycle; pop is resolved before push so a full FIFO can accept
  always_comb begin
    sum = acc + ACC_W'(bus.adc_data);
    avg = DATA_W'(sum >> AVG_LOG2);
    push_req = bus.adc_valid && (cnt == '1);
    do_pop = bus.rd_en && !bus.empty;
    do_push = push_req && (!bus.full || do_pop);
    drop = push_req && bus.full && !do_pop;
    count_nx = bus.count + CW'(do_push) - CW'(do_pop);
  end
  // accumulator, wrapping sample counter and live LED value
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
      bus.led_dout <= '0;
    end else if (bus.adc_valid) begin
      acc <= push_req ? '0 : sum;
      cnt <= cnt + 1'b1;
      if (push_req) bus.led_dout <= avg[DATA_W-1 -: LED_W];
    end
  // pointers, occupancy and registered status flags; a drop beats a same-cycle clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      bus.count <= '0;
      bus.empty <= 1'b1;
      bus.full <= 1'b0;
      bus.overflow <= 1'b0;
      bus.rd_valid <= 1'b0;
    end else begin
      wptr <= wptr + DEPTH_LOG2'(do_push);
      rptr <= rptr + DEPTH_LOG2'(do_pop);
      bus.count <= count_nx;
      bus.empty <= count_nx == '0;
      bus.full <= count_nx == CW'(DEPTH);
      bus.overflow <= drop || (bus.overflow && !bus.ovf_clr);
      bus.rd_valid <= do_pop;
    end
  sample_ram #(.W(DATA_W), .A(DEPTH_LOG2)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(do_push),
    .waddr(wptr),
    .wdata(avg),
    .re(do_pop),
    .raddr(rptr),
    .rdata(bus.rd_data)
  );
endmodule

// File: tb/tb_adc_sample_buffer.sv
// tb_adc_sample_buffer: directed and random stimulus against a queue-based reference model
module tb_adc_sample_buffer;
  import temp_pkg::*;
  localparam int N = 1 << AVG_LOG2_DEF;
  localparam int DEPTH = 1 << DEPTH_LOG2_DEF;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  adc_sample_buffer_if bus ();
  adc_sample_buffer dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int samp[$];
  int fifo[$];
  int m_led, m_rd, m_ovf, m_rv;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("count", 32'(bus.count), fifo.size());
    chk("empty", 32'(bus.empty), fifo.size() == 0);
    chk("full", 32'(bus.full), fifo.size() == DEPTH);
    chk("overflow", 32'(bus.overflow), m_ovf);
    chk("rd_valid", 32'(bus.rd_valid), m_rv);
    chk("rd_data", 32'(bus.rd_data), m_rd);
    chk("led_dout", 32'(bus.led_dout), m_led);
  endtask
  task automatic model_reset();
    samp.delete();
    fifo.delete();
    m_led = 0;
    m_rd = 0;
    m_ovf = 0;
    m_rv = 0;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    check_all();
  endtask
  task automatic step(bit v, int d, bit r, bit c);
    int sum, avg;
    bus.adc_valid = v;
    bus.adc_data = d[11:0];
    bus.rd_en = r;
    bus.ovf_clr = c;
    @(posedge clk);
    #1;
    if (c) m_ovf = 0;
    m_rv = 0;
    if (r && fifo.size() > 0) begin
      m_rd = fifo.pop_front();
      m_rv = 1;
    end
    if (v) begin
      samp.push_back(d & 'hFFF);
      if (samp.size() == N) begin
        sum = 0;
        foreach (samp[i]) sum += samp[i];
        avg = sum / N;
        m_led = avg >> 4;
        samp.delete();
        if (fifo.size() < DEPTH) fifo.push_back(avg);
        else m_ovf = 1;
      end
    end
    bus.adc_valid = 1'b0;
    bus.rd_en = 1'b0;
    bus.ovf_clr = 1'b0;
    check_all();
  endtask
  task automatic feed(int d);
    for (int i = 0; i < N; i++) step(1'b1, d, 1'b0, 1'b0);
  endtask
  task automatic feed_rand();
    for (int i = 0; i < N; i++) step(1'b1, int'($urandom), 1'b0, 1'b0);
  endtask
  initial begin
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    bus.rd_en = 1'b0;
    bus.ovf_clr = 1'b0;
    do_reset();
    feed('h800);
    chk("mid_led", 32'(bus.led_dout), 'h80);
    chk("mid_count", 32'(bus.count), 1);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("mid_rd", 32'(bus.rd_data), 'h800);
    for (int i = 0; i < N; i++) step(1'b1, i, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("ramp_avg", 32'(bus.rd_data), 3);
    feed('hFFF);
    chk("max_led", 32'(bus.led_dout), 'hFF);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("max_avg", 32'(bus.rd_data), 'hFFF);
    for (int v = 0; v < DEPTH; v++) feed(v);
    chk("fill_full", 32'(bus.full), 1);
    feed('h3AB);
    chk("drop_ovf", 32'(bus.overflow), 1);
    chk("drop_led", 32'(bus.led_dout), 'h3A);
    for (int v = 0; v < DEPTH; v++) begin
      step(1'b0, 0, 1'b1, 1'b0);
      chk("drain_seq", 32'(bus.rd_data), v);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 0);
    for (int v = 0; v < DEPTH; v++) feed_rand();
    for (int i = 0; i < N - 1; i++) step(1'b1, int'($urandom), 1'b0, 1'b0);
    step(1'b1, int'($urandom), 1'b1, 1'b0);
    chk("coinc_count", 32'(bus.count), DEPTH);
    chk("coinc_ovf", 32'(bus.overflow), 0);
    for (int v = 0; v < DEPTH; v++) step(1'b0, 0, 1'b1, 1'b0);
    chk("drained", 32'(bus.empty), 1);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 'hFFF, 1'b0, 1'b0);
    do_reset();
    feed('h100);
    chk("rst_count", 32'(bus.count), 1);
    step(1'b0, 0, 1'b1, 1'b0);
    chk("rst_avg", 32'(bus.rd_data), 'h100);
    for (int i = 0; i < 64; i++) step(1'b1, int'($urandom), 1'b0, 1'b0);
    chk("cont_count", 32'(bus.count), 8);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), int'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
